// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and the
// default address/instruction width.
package pc_seq_pkg;

  localparam int unsigned PC_SEQ_WIDTH = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FLUSH = 2'd3
  } pc_seq_state_e;

endpackage

// File: rtl/pcadder.sv
// Modular PC adder: C = A + B truncated to WIDTH bits, no carry out,
// so the PC wraps naturally at the top of the address space.
module pcadder #(
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);

  assign C = A + B;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> ISSUE loop with branch
// redirect through a one-cycle FLUSH state. All outputs are registered.
// Optional feature: define PC_SEQ_LINK_EN to add the CALL input and the
// LINK (return address) output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH    = PC_SEQ_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(16'h0000),
  parameter int unsigned      STEP     = 32'd1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             HALT,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic             IMEM_ACK,
  input  logic [WIDTH-1:0] IMEM_DATA,
  output logic             INSTR_VALID,
  output logic [WIDTH-1:0] INSTR,
  output logic [WIDTH-1:0] INSTR_PC,
  input  logic             INSTR_READY,
  input  logic             BR_TAKEN,
  input  logic [WIDTH-1:0] BR_TARGET,
`ifdef PC_SEQ_LINK_EN
  input  logic             CALL,
  output logic [WIDTH-1:0] LINK,
`endif
  output logic [WIDTH-1:0] PC
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_seq_state_e    state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] pc_inc_s;

  pcadder #(.WIDTH(WIDTH)) u_pc_inc (
    .A (pc_q),
    .B (STEP_W),
    .C (pc_inc_s)
  );

  // Next-state, PC and capture logic; branch redirect outranks ACK/READY/HALT
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (BR_TAKEN) begin
          pc_d = BR_TARGET;
        end else if (EN) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (BR_TAKEN) begin
          pc_d    = BR_TARGET;
          state_d = ST_FLUSH;
        end else if (IMEM_ACK) begin
          instr_d    = IMEM_DATA;
          instr_pc_d = pc_q;
          pc_d       = pc_inc_s;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (BR_TAKEN) begin
          pc_d    = BR_TARGET;
          state_d = ST_FETCH;
        end else if (INSTR_READY) begin
          state_d = HALT ? ST_IDLE : ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if (BR_TAKEN) begin
          pc_d = BR_TARGET;
        end else begin
          pc_d = pc_q;
        end
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they are registered
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_ISSUE);
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef PC_SEQ_LINK_EN
  logic [WIDTH-1:0] link_q, link_d;
  logic [WIDTH-1:0] link_inc_s;

  pcadder #(.WIDTH(WIDTH)) u_link_inc (
    .A (instr_pc_q),
    .B (STEP_W),
    .C (link_inc_s)
  );

  // Return address is captured on a taken call while an instruction is issuing
  always_comb begin
    link_d = link_q;
    if ((state_q == ST_ISSUE) && BR_TAKEN && CALL) begin
      link_d = link_inc_s;
    end else begin
      link_d = link_q;
    end
  end

  // Link register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      link_q <= '0;
    end else begin
      link_q <= link_d;
    end
  end

  assign LINK = link_q;
`else
  // Without the link feature there is no return-address state at all.
`endif

  assign IMEM_REQ    = imem_req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR_VALID = instr_valid_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign PC          = pc_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, PC value after reset.
REQ-003 SHALL have parameter STEP, default 1, PC increment per fetched instruction.
REQ-004 SHALL have port CLK  input  1  clock, rising-edge active.
REQ-005 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  input  1  start fetching from IDLE.
REQ-007 SHALL have port HALT  input  1  stop fetching after the current issue completes.
REQ-008 SHALL have port IMEM_REQ  output  1  instruction-memory read request.
REQ-009 SHALL have port IMEM_ADDR  output  WIDTH  read address; equals PC.
REQ-010 SHALL have port IMEM_ACK  input  1  read data valid this cycle.
REQ-011 SHALL have port IMEM_DATA  input  WIDTH  read data.
REQ-012 SHALL have port INSTR_VALID  output  1  INSTR/INSTR_PC valid to decode.
REQ-013 SHALL have port INSTR  output  WIDTH  captured instruction.
REQ-014 SHALL have port INSTR_PC  output  WIDTH  address INSTR was fetched from.
REQ-015 SHALL have port INSTR_READY  input  1  decode accepts INSTR.
REQ-016 SHALL have port BR_TAKEN  input  1  redirect request.
REQ-017 SHALL have port BR_TARGET  input  WIDTH  redirect address.
REQ-018 SHALL have port PC  output  WIDTH  current fetch PC.

Function
REQ-019 SHALL implement states IDLE, FETCH, ISSUE, FLUSH.
REQ-020 IDLE: IMEM_REQ=0, INSTR_VALID=0; EN=1 -> FETCH next cycle.
REQ-021 FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable until IMEM_ACK.
REQ-022 FETCH with IMEM_ACK=1: INSTR<=IMEM_DATA, INSTR_PC<=PC, PC<=PC+STEP, -> ISSUE; one-cycle latency ACK-to-INSTR_VALID.
REQ-023 ISSUE: INSTR_VALID=1, INSTR/INSTR_PC stable until INSTR_READY=1.
REQ-024 ISSUE with INSTR_READY=1: -> IDLE if HALT=1, else FETCH; INSTR_VALID=0 next cycle.
REQ-025 PC+STEP SHALL wrap modulo 2^WIDTH (16'hFFFF+1 -> 16'h0000), no carry out.
REQ-026 BR_TAKEN=1 in FETCH, ISSUE or FLUSH SHALL set PC<=BR_TARGET, clear INSTR_VALID, and take priority over IMEM_ACK, INSTR_READY and HALT.
REQ-027 BR_TAKEN in FETCH -> FLUSH (IMEM_REQ=0 one cycle, data of a same-cycle ACK discarded), then FETCH at BR_TARGET.
REQ-028 BR_TAKEN in ISSUE -> FETCH at BR_TARGET; pending INSTR dropped.
REQ-029 BR_TAKEN in IDLE SHALL load PC only; state unchanged.
REQ-030 IMEM_ACK outside FETCH SHALL be ignored.

Reset
REQ-031 RESET_N=0 SHALL immediately force state IDLE, PC=RESET_PC, IMEM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, including mid-fetch or mid-issue.
REQ-032 First FETCH after reset release SHALL require EN=1.

Configuration
REQ-033 Macro PC_SEQ_LINK_EN SHALL enable input CALL (1) and output LINK (WIDTH).
REQ-034 With PC_SEQ_LINK_EN: BR_TAKEN=1 and CALL=1 in ISSUE SHALL load LINK<=INSTR_PC+STEP (wrapping); LINK resets to 0, else holds.
REQ-035 Without PC_SEQ_LINK_EN: CALL and LINK ports and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum and the WIDTH default constant.
REQ-037 The increment SHALL instantiate the existing pcadder (A=PC, B=STEP, C=next PC).

Verification
REQ-038 Reset, EN=1, ACK on 2nd FETCH cycle with DATA=16'h1234, READY=1 -> INSTR=16'h1234, INSTR_PC=0, PC=1, INSTR_VALID one cycle.
REQ-039 RESET_PC=16'hFFFF, one fetch -> INSTR_PC=16'hFFFF, PC=16'h0000.
REQ-040 BR_TAKEN with BR_TARGET=16'h0040 in same cycle as IMEM_ACK -> data discarded, one cycle IMEM_REQ=0, next IMEM_ADDR=16'h0040.
REQ-041 READY held 0 for 5 cycles in ISSUE -> INSTR stable, IMEM_REQ=0; HALT=1 with READY -> IDLE.
REQ-042 RESET_N=0 mid-FETCH -> IMEM_REQ=0 and PC=RESET_PC before next CLK edge.
REQ-043 With PC_SEQ_LINK_EN, CALL+BR_TAKEN at INSTR_PC=16'h0010 -> LINK=16'h0011, PC=BR_TARGET.
